// File: rtl/rv32_stage_fifo.sv
// rv32_stage_fifo: elastic valid/ready buffer that sits between two RV32
// pipeline stages. The stage record is carried as an opaque DATA_W vector in a
// DEPTH-entry circular buffer. It supports backpressure, multi-entry buffering
// and flush with bubble fill. BUBBLE is driven on out_data whenever the buffer
// is empty.
// Optional feature: define RV32_STAGE_FIFO_STATS_EN to add the saturating
// stall_cycles output. The counter is cleared by rst only.
module rv32_stage_fifo #(
  parameter int                 DATA_W = 64,
  parameter int                 DEPTH  = 2,
  parameter logic [DATA_W-1:0]  BUBBLE = DATA_W'(64'h0000_0013_0000_0000)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
`ifdef RV32_STAGE_FIFO_STATS_EN
  output logic [31:0]                   stall_cycles,
`endif
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              push, pop;

  // Pointer advance with wrap at DEPTH-1. This also covers non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake outputs come from registered occupancy only. This keeps
  // out_ready out of the in_ready path.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
  assign count     = count_q;

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Next-state for pointers and occupancy. Flush returns everything to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register. rst takes priority over the flush handling above.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset. Flush leaves stale contents behind because
  // the count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef RV32_STAGE_FIFO_STATS_EN
  logic [31:0] stall_q, stall_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Upstream stall counting. A cycle counts when a valid entry is refused and
  // no flush is in progress.
  always_comb begin
    stall_d = stall_q;
    if (in_valid & ~in_ready & ~flush) stall_d = sat_inc32(stall_q);
  end

  // Stall counter register. It is cleared by rst only and survives a flush.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rv32_stage_fifo.sv
// Directed bench for rv32_stage_fifo. It drives three instances: DEPTH=2, 3 and 1.
module tb_rv32_stage_fifo;

  localparam logic [63:0] BUB = 64'h0000_0013_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DEPTH = 2 instance
  logic        fl2, iv2, ir2, ov2, or2;
  logic [63:0] id2, od2;
  logic [1:0]  cnt2;
  // DEPTH = 3 instance
  logic        fl3, iv3, ir3, ov3, or3;
  logic [63:0] id3, od3;
  logic [1:0]  cnt3;
  // DEPTH = 1 instance
  logic        fl1, iv1, ir1, ov1, or1;
  logic [63:0] id1, od1;
  logic [0:0]  cnt1;
`ifdef RV32_STAGE_FIFO_STATS_EN
  logic [31:0] st2, st3, st1;
`endif

  rv32_stage_fifo #(.DATA_W(64), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .in_ready(ir2),
    .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_data(od2),
`ifdef RV32_STAGE_FIFO_STATS_EN
    .stall_cycles(st2),
`endif
    .count(cnt2));

  rv32_stage_fifo #(.DATA_W(64), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_ready(or3), .out_data(od3),
`ifdef RV32_STAGE_FIFO_STATS_EN
    .stall_cycles(st3),
`endif
    .count(cnt3));

  rv32_stage_fifo #(.DATA_W(64), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
`ifdef RV32_STAGE_FIFO_STATS_EN
    .stall_cycles(st1),
`endif
    .count(cnt1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fl2 = 0; iv2 = 0; or2 = 0; id2 = '0;
    fl3 = 0; iv3 = 0; or3 = 0; id3 = '0;
    fl1 = 0; iv1 = 0; or1 = 0; id1 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (cnt2 !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt2); end
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ov2); end
    total++; if (od2 !== BUB) begin bad++; $display("FAIL reset_out_data got=%h exp=%h", od2, BUB); end
    total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ir2); end
    total++; if (cnt3 !== 2'd0 || cnt1 !== 1'd0) begin bad++; $display("FAIL reset_count_other got=%0d/%0d exp=0/0", cnt3, cnt1); end
`ifdef RV32_STAGE_FIFO_STATS_EN
    total++; if (st2 !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", st2); end
`endif
  endtask

  task automatic test_fill_backpressure();
    or2 = 0; iv2 = 1; id2 = 64'hA;
    tick();
    total++; if (cnt2 !== 2'd1) begin bad++; $display("FAIL fill_count1 got=%0d exp=1", cnt2); end
    id2 = 64'hB;
    tick();
    total++; if (cnt2 !== 2'd2) begin bad++; $display("FAIL fill_count2 got=%0d exp=2", cnt2); end
    total++; if (ir2 !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", ir2); end
    id2 = 64'hC;
    tick();
    total++; if (cnt2 !== 2'd2) begin bad++; $display("FAIL blocked_count got=%0d exp=2", cnt2); end
    total++; if (od2 !== 64'hA) begin bad++; $display("FAIL blocked_out_data got=%h exp=a", od2); end
    total++; if (ir2 !== 1'b0) begin bad++; $display("FAIL blocked_in_ready got=%b exp=0", ir2); end
`ifdef RV32_STAGE_FIFO_STATS_EN
    total++; if (st2 !== 32'd1) begin bad++; $display("FAIL blocked_stall got=%0d exp=1", st2); end
`endif
  endtask

  task automatic test_drain_wrap();
    or2 = 1;  // in_data still 0xC, in_valid still 1
    tick();   // pop A, C refused
    total++; if (cnt2 !== 2'd1) begin bad++; $display("FAIL drain1_count got=%0d exp=1", cnt2); end
    total++; if (od2 !== 64'hB) begin bad++; $display("FAIL drain1_out_data got=%h exp=b", od2); end
`ifdef RV32_STAGE_FIFO_STATS_EN
    total++; if (st2 !== 32'd2) begin bad++; $display("FAIL drain1_stall got=%0d exp=2", st2); end
`endif
    tick();   // push C and pop B together
    total++; if (cnt2 !== 2'd1) begin bad++; $display("FAIL drain2_count got=%0d exp=1", cnt2); end
    total++; if (od2 !== 64'hC) begin bad++; $display("FAIL drain2_out_data got=%h exp=c", od2); end
    iv2 = 0;
    tick();   // pop C
    total++; if (ov2 !== 1'b0 || od2 !== BUB) begin bad++; $display("FAIL drain3_empty got=%b/%h exp=0/%h", ov2, od2, BUB); end
    or2 = 0; iv2 = 1; id2 = 64'hD;  // lands in slot 1 after the wrap
    tick();
    total++; if (od2 !== 64'hD || cnt2 !== 2'd1) begin bad++; $display("FAIL wrap_push got=%h/%0d exp=d/1", od2, cnt2); end
  endtask

  task automatic test_flush();
    id2 = 64'hE;
    tick();
    total++; if (cnt2 !== 2'd2) begin bad++; $display("FAIL preflush_count got=%0d exp=2", cnt2); end
    fl2 = 1; iv2 = 1; or2 = 1; id2 = 64'hF;
    tick();
    total++; if (cnt2 !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", cnt2); end
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", ov2); end
    total++; if (od2 !== BUB) begin bad++; $display("FAIL flush_out_data got=%h exp=%h", od2, BUB); end
`ifdef RV32_STAGE_FIFO_STATS_EN
    total++; if (st2 !== 32'd2) begin bad++; $display("FAIL flush_stall got=%0d exp=2", st2); end
`endif
    fl2 = 0; iv2 = 0; or2 = 0;
    tick();
    total++; if (ov2 !== 1'b0 || cnt2 !== 2'd0) begin bad++; $display("FAIL postflush got=%b/%0d exp=0/0", ov2, cnt2); end
  endtask

  task automatic test_reset_midop();
    iv2 = 1; id2 = 64'h55;
    tick();
    iv2 = 0; rst = 1;
    tick();
    rst = 0;
    total++; if (cnt2 !== 2'd0 || od2 !== BUB) begin bad++; $display("FAIL midrst got=%0d/%h exp=0/%h", cnt2, od2, BUB); end
`ifdef RV32_STAGE_FIFO_STATS_EN
    total++; if (st2 !== 32'd0) begin bad++; $display("FAIL midrst_stall got=%0d exp=0", st2); end
`endif
  endtask

  task automatic test_back_to_back();
    iv3 = 1; or3 = 0; id3 = 64'd100;
    tick();
    total++; if (cnt3 !== 2'd1) begin bad++; $display("FAIL b2b_prime got=%0d exp=1", cnt3); end
    or3 = 1;
    for (int i = 0; i < 10; i++) begin
      id3 = 64'd101 + 64'(i);
      total++; if (od3 !== 64'd100 + 64'(i)) begin bad++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, od3, 100 + i); end
      total++; if (cnt3 !== 2'd1) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, cnt3); end
      tick();
    end
    iv3 = 0; or3 = 0;
    total++; if (od3 !== 64'd110) begin bad++; $display("FAIL b2b_last got=%0d exp=110", od3); end
  endtask

  task automatic test_depth1_stream();
    int pops = 0;
    int pushes = 0;
    iv1 = 1; or1 = 1; id1 = 64'd200;
    for (int i = 0; i < 8; i++) begin
      logic acc;
      total++; if (ir1 !== ((i % 2) == 0)) begin bad++; $display("FAIL d1_in_ready[%0d] got=%b exp=%b", i, ir1, (i % 2) == 0); end
      if (ov1 === 1'b1) begin
        total++; if (od1 !== 64'd200 + 64'(pops)) begin bad++; $display("FAIL d1_data[%0d] got=%0d exp=%0d", i, od1, 200 + pops); end
        pops++;
      end
      acc = ir1;
      tick();
      if (acc) begin pushes++; id1 = 64'd200 + 64'(pushes); end
    end
    iv1 = 0; or1 = 0;
    total++; if (pops != 4) begin bad++; $display("FAIL d1_transfers got=%0d exp=4", pops); end
  endtask

  initial begin
    test_reset();
    test_fill_backpressure();
    test_drain_wrap();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    test_depth1_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_stage_fifo.md
# rv32_stage_fifo

Parametrised elastic pipeline-stage buffer for the RV32 pipeline, replacing the fixed single-entry IF/ID, ID/EX, EX/MEM and MEM/WB registers with a valid/ready buffer of configurable payload width and depth. The buffer sits between two adjacent stages and carries a packed stage struct (for example the 64-bit IF/ID record) as an opaque vector. It adds three behaviours the plain stage registers lack: backpressure, multi-entry buffering, and flush with bubble fill.

## Interface
- DATA_W, default 64: payload width in bits. Equals the packed width of the carried stage struct.
- DEPTH, default 2: number of entries. Legal values are 1 or more; non-power-of-two values are supported.
- BUBBLE, default 64'h0000001300000000: value driven on out_data when the buffer is empty. It encodes a NOP (addi x0,x0,0) in the upper 32 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all held entries (branch taken or trap).
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_data  in  DATA_W  payload from the upstream stage.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_data  out  DATA_W  oldest held entry, or BUBBLE when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is a circular buffer of DEPTH entries with a write pointer, a read pointer and an occupancy count.
- Each pointer advances by 1 and wraps from DEPTH-1 to 0.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- in_ready = (count < DEPTH). It is derived from state only and never depends on out_ready.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when count != 0, otherwise BUBBLE.
- Count update:
  - push only: count +1.
  - pop only: count -1.
  - push and pop together: count unchanged, both pointers advance.
- Full (count == DEPTH): in_ready = 0. A simultaneous out_ready frees the slot, but the new entry is not accepted until the next cycle.
- Empty (count == 0): out_valid = 0 and out_ready is ignored. A push in this cycle is visible on out_data in the next cycle; there is no combinational bypass.
- Flush:
  - On the next edge, count and both pointers go to 0.
  - Any in_valid in the flush cycle is dropped.
  - Any out_ready in the flush cycle does not count as a pop.
  - Storage contents are not cleared.
- Flush takes priority over push and pop. rst takes priority over flush.
- The upstream stage must hold in_data and in_valid stable while in_valid & !in_ready; the buffer does not check this.

## Timing
- Reset values, effective after the first rising edge with rst = 1:
  - count = 0, out_valid = 0, out_data = BUBBLE, in_ready = 1.
  - Pointers = 0.
- Reset mid-operation has the same effect as a flush plus clearing of the statistics counter.
- Latency from push to out_valid is 1 cycle.
- Sustained throughput is 1 entry/cycle while 0 < count < DEPTH, or while count == DEPTH with pops each cycle at DEPTH ≥ 2.
- With DEPTH = 1, throughput is 1 entry every 2 cycles under continuous flow. This is the accepted cost of a registered in_ready.
- in_ready, out_valid, out_data and count are functions of registered state only; no input-to-output combinational paths.

## Configuration
- RV32_STAGE_FIFO_STATS_EN defined:
  - Adds output port stall_cycles (out, 32 bits).
  - It increments each cycle with in_valid & !in_ready & !flush and saturates at 32'hFFFFFFFF.
  - Cleared by rst only; flush does not clear it.
- Not defined: no port and no counter logic; all other behaviour is identical.

## Test plan
- Reset and empty: rst = 1 for 2 cycles, then in_valid = 0 → count = 0, out_valid = 0, out_data = 64'h0000001300000000, in_ready = 1.
- Fill and backpressure: DEPTH = 2, out_ready = 0, push 64'hA, 64'hB, then attempt 64'hC.
  - Required: count = 2 and in_ready = 0.
  - 64'hC is not accepted.
  - out_data = 64'hA.
  - With the macro defined, stall_cycles = 1 after one blocked cycle.
- Full drain and wrap: continue from the previous scenario with out_ready = 1 and 64'hC held on in_data.
  - Cycle 1: pop 64'hA; count = 1.
  - Cycle 2: push 64'hC and pop 64'hB together; count stays 1.
  - Cycle 3: out_data = 64'hC.
  - The write pointer has wrapped to 1.
- Simultaneous push/pop: DEPTH = 3, count = 1, in_valid = out_ready = 1 for 10 cycles with an incrementing payload → count stays 1 and outputs appear in order, each 1 cycle after entry.
- Flush priority: count = 2, with flush = 1, in_valid = 1 and out_ready = 1 in the same cycle.
  - Next cycle: count = 0, out_valid = 0, out_data = BUBBLE.
  - The input presented in the flush cycle is never output.
- DEPTH = 1 streaming: in_valid = out_ready = 1 continuously for 8 cycles → exactly 4 entries are transferred, alternating in_ready = 1 and in_ready = 0.
